mmu_bus_arbiter: RTL
====================

Name: mmu_bus_arbiter

Overview:
- Shares one single-ported backing memory bus between the core's three MMU requesters: instruction read, data read and data write.
- Sits between the core's MMU connection and the memory/bus bridge.
- Captures all requests presented in one cycle and serialises them in a fixed priority order.
- Drives MEM_WAIT to freeze the pipeline until every captured request completes, then returns the read results together in a single release cycle.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- TIMEOUT_CYCLES, 255, watchdog limit per backend transaction; used only when ARB_TIMEOUT_EN is defined; range 1..65535.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- INST_RDEN  in  1  instruction read request.
- INST_RIADDR  in  ADDR_W  instruction read address.
- INST_ROADDR  out  ADDR_W  address of the returned instruction.
- INST_RVALID  out  1  instruction data valid.
- INST_RDATA  out  DATA_W  instruction word.
- DATA_RDEN  in  1  data read request.
- DATA_RIADDR  in  ADDR_W  data read address.
- DATA_ROADDR  out  ADDR_W  address of the returned data.
- DATA_RVALID  out  1  data read valid.
- DATA_RDATA  out  DATA_W  read data.
- DATA_WREN  in  1  data write request.
- DATA_WADDR  in  ADDR_W  write address.
- DATA_WDATA  in  DATA_W  write data.
- MEM_WAIT  out  1  pipeline hold to the core.
- MEM_REQ  out  1  backend transaction request.
- MEM_WE  out  1  backend write (1) / read (0).
- MEM_ADDR  out  ADDR_W  backend address.
- MEM_WDATA  out  DATA_W  backend write data.
- MEM_ACK  in  1  backend completion; one-cycle pulse.
- MEM_RDATA  in  DATA_W  backend read data; valid when MEM_ACK=1 and MEM_WE=0.
- MEM_ERR  out  1  timeout pulse; tied 0 unless ARB_TIMEOUT_EN is defined.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; pending flags, address latches and data latches cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - MEM_WAIT = DATA_WREN | DATA_RDEN | INST_RDEN, combinational.
  - If any request is asserted, on that edge latch the three enables plus all addresses and write data into pending flags, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - MEM_WAIT=1.
  - Serves the highest-priority pending flag; priority is write > data read > instruction read.
  - MEM_REQ=1 with MEM_WE, MEM_ADDR and MEM_WDATA registered and held stable until MEM_ACK.
  - MEM_ACK is sampled only while MEM_REQ=1; an ACK while MEM_REQ=0 is ignored.
  - On ACK: clear the served flag; for a read, latch MEM_RDATA and the address into the matching R*DATA/RO*ADDR register.
  - If flags remain after an ACK, the next transaction starts the following cycle with no idle gap.
  - When the last flag clears, MEM_REQ drops and the FSM goes to DONE.
- DONE, exactly one cycle:
  - MEM_WAIT=0.
  - INST_RVALID / DATA_RVALID = 1 only for reads served in this batch.
  - Next state is IDLE.
  - RDATA/ROADDR hold their values until overwritten by a later read of the same type.
- Request inputs are ignored outside IDLE; the core holds them stable under MEM_WAIT, and any change is not observed.
- Latency: a lone read with ACK in the first REQ cycle gives IDLE (t), BUSY (t+1), DONE (t+2). MEM_WAIT is high in t and t+1; RVALID is high in t+2.
- Write followed by read of the same address in one batch: the write completes first, so the read returns the new value.
- A write-only batch still passes through DONE with both RVALIDs at 0.
- Asynchronous reset mid-transaction: MEM_REQ and MEM_WAIT drop immediately and pending work is discarded. A late MEM_ACK after reset is ignored.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears at each transaction start and increments each BUSY cycle without ACK.
  - When the counter reaches TIMEOUT_CYCLES, the transaction is aborted: MEM_REQ drops that edge and MEM_ERR pulses 1 cycle.
  - For a read, the corresponding RDATA is forced to 0; the flag is cleared and sequencing continues normally.
- When undefined: no counter; BUSY waits indefinitely for MEM_ACK; MEM_ERR is constant 0.

Test Plan:
- Reset, then INST_RDEN=1 at addr 0x2000_0000 with ACK on first REQ cycle and MEM_RDATA=0x0000_0013 -> MEM_WAIT high 2 cycles; third cycle INST_RVALID=1, INST_RDATA=0x13, INST_ROADDR=0x2000_0000.
- Write 0x1000/0xDEAD_BEEF, data read 0x1000 and inst read 0x2000_0004 all asserted in the same cycle -> MEM_REQ sequence is WE=1 @0x1000, WE=0 @0x1000, WE=0 @0x2000_0004; a backend model returns 0xDEAD_BEEF for the data read; single DONE cycle with both RVALIDs=1.
- MEM_ACK delayed 5 cycles on a data read -> MEM_ADDR stable for all 5 cycles; MEM_WAIT high for 6 cycles total before the DONE cycle.
- Spurious MEM_ACK while idle, and input changes during BUSY -> no state change; the originally latched addresses are used.
- RST asserted in the 2nd BUSY cycle -> MEM_REQ, MEM_WAIT and RVALIDs are 0 before the next clock edge; after release the FSM is in IDLE.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ACK on a data read -> MEM_ERR pulses after 4 BUSY cycles; DONE follows with DATA_RVALID=1 and DATA_RDATA=0.

Source files
------------

// File: rtl/mmu_bus_arbiter.sv
// Serialises the MMU's instruction-read, data-read and data-write requests onto one memory bus.
// Optional per-transaction watchdog is enabled by defining ARB_TIMEOUT_EN.
module mmu_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INST_RDEN,
  input  logic [ADDR_W-1:0] INST_RIADDR,
  output logic [ADDR_W-1:0] INST_ROADDR,
  output logic              INST_RVALID,
  output logic [DATA_W-1:0] INST_RDATA,
  input  logic              DATA_RDEN,
  input  logic [ADDR_W-1:0] DATA_RIADDR,
  output logic [ADDR_W-1:0] DATA_ROADDR,
  output logic              DATA_RVALID,
  output logic [DATA_W-1:0] DATA_RDATA,
  input  logic              DATA_WREN,
  input  logic [ADDR_W-1:0] DATA_WADDR,
  input  logic [DATA_W-1:0] DATA_WDATA,
  output logic              MEM_WAIT,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_ERR
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  state_e            state_q;
  logic              wr_pend_q, dr_pend_q, ir_pend_q;
  logic              dr_batch_q, ir_batch_q;
  logic [ADDR_W-1:0] dr_addr_q, ir_addr_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              inst_rvalid_q, data_rvalid_q;
  logic [ADDR_W-1:0] inst_roaddr_q, data_roaddr_q;
  logic [DATA_W-1:0] inst_rdata_q, data_rdata_q;

  logic              any_req_c, ack_c, tmo_c, end_c;
  logic              serve_dr_c, dr_left_c, ir_left_c;
  logic [DATA_W-1:0] rdata_c;

  // Write is always served first, so only the read flags can survive an ACK.
  always_comb begin
    any_req_c  = DATA_WREN | DATA_RDEN | INST_RDEN;
    ack_c      = mem_req_q & MEM_ACK;
    end_c      = ack_c | tmo_c;
    serve_dr_c = ~wr_pend_q & dr_pend_q;
    dr_left_c  = dr_pend_q & wr_pend_q;
    ir_left_c  = ir_pend_q & (wr_pend_q | dr_pend_q);
    rdata_c    = tmo_c ? '0 : MEM_RDATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      wr_pend_q     <= 1'b0;
      dr_pend_q     <= 1'b0;
      ir_pend_q     <= 1'b0;
      dr_batch_q    <= 1'b0;
      ir_batch_q    <= 1'b0;
      dr_addr_q     <= '0;
      ir_addr_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      inst_roaddr_q <= '0;
      data_roaddr_q <= '0;
      inst_rdata_q  <= '0;
      data_rdata_q  <= '0;
    end else begin
      inst_rvalid_q <= 1'b0;
      data_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            state_q    <= BUSY;
            wr_pend_q  <= DATA_WREN;
            dr_pend_q  <= DATA_RDEN;
            ir_pend_q  <= INST_RDEN;
            dr_batch_q <= DATA_RDEN;
            ir_batch_q <= INST_RDEN;
            dr_addr_q  <= DATA_RIADDR;
            ir_addr_q  <= INST_RIADDR;
            mem_req_q  <= 1'b1;
            if (DATA_WREN) begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= DATA_WADDR;
              mem_wdata_q <= DATA_WDATA;
            end else begin
              mem_we_q    <= 1'b0;
              mem_addr_q  <= DATA_RDEN ? DATA_RIADDR : INST_RIADDR;
              mem_wdata_q <= '0;
            end
          end
        end
        BUSY: begin
          if (end_c) begin
            if (!mem_we_q) begin
              if (serve_dr_c) begin
                data_rdata_q  <= rdata_c;
                data_roaddr_q <= mem_addr_q;
              end else begin
                inst_rdata_q  <= rdata_c;
                inst_roaddr_q <= mem_addr_q;
              end
            end
            wr_pend_q   <= 1'b0;
            dr_pend_q   <= dr_left_c;
            ir_pend_q   <= ir_left_c;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            if (dr_left_c) begin
              mem_addr_q <= dr_addr_q;
            end else if (ir_left_c) begin
              mem_addr_q <= ir_addr_q;
            end else begin
              mem_req_q     <= 1'b0;
              state_q       <= DONE;
              inst_rvalid_q <= ir_batch_q;
              data_rvalid_q <= dr_batch_q;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        mem_err_q;

  assign tmo_c = mem_req_q & ~MEM_ACK & (cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting on the current backend transaction.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      mem_err_q <= tmo_c;
      if (state_q != BUSY || end_c) cnt_q <= '0;
      else                          cnt_q <= cnt_q + 16'd1;
    end
  end

  assign MEM_ERR = mem_err_q;
`else
  assign tmo_c   = 1'b0;
  assign MEM_ERR = 1'b0;
`endif

  // Hold is combinational in IDLE so the core stalls in the same cycle it requests.
  assign MEM_WAIT    = ~RST & ((state_q == IDLE && any_req_c) || state_q == BUSY);
  assign MEM_REQ     = mem_req_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;
  assign INST_RVALID = inst_rvalid_q;
  assign INST_RDATA  = inst_rdata_q;
  assign INST_ROADDR = inst_roaddr_q;
  assign DATA_RVALID = data_rvalid_q;
  assign DATA_RDATA  = data_rdata_q;
  assign DATA_ROADDR = data_roaddr_q;

endmodule
